wb_initiator: RTL and testbench
===============================

# wb_initiator

Wishbone classic initiator that turns a simple command/response handshake into single-beat or incrementing-burst Wishbone read/write cycles on the user-area bus. It is the initiator-side counterpart of the Wishbone responders in the user project. It lets logic-analyzer probes or other user logic drive the responder peripherals without the management SoC. It issues one transfer at a time and applies response backpressure per beat. An optional watchdog aborts transfers that the responder never acknowledges.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width; SEL_W = DATA_W/8
- LEN_W, 8, width of burst-length field
- TIMEOUT, 255, cycles without ack before abort (watchdog builds only); must be ≥ 1

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  start byte address
- cmd_wdata  in  DATA_W  write data, repeated on every beat
- cmd_sel  in  SEL_W  byte selects, every beat
- cmd_len  in  LEN_W  beats minus one (0 → 1 beat, max 2^LEN_W beats)
- rsp_valid  out  1  beat response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  beat aborted by watchdog
- rsp_last  out  1  final response of the command
- busy  out  1  state ≠ IDLE
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls
- wbm_adr_o  out  ADDR_W;  wbm_sel_o  out  SEL_W;  wbm_dat_o  out  DATA_W
- wbm_dat_i  in  DATA_W;  wbm_ack_i  in  1

## Operation
- All outputs registered. Reset value of every output is 0. State after reset is IDLE.
- **IDLE**
  - cmd_ready = 1.
  - On accept, latch we/addr/wdata/sel and set beats_left = cmd_len.
  - Go to REQ.
- **REQ**
  - wbm_cyc_o = wbm_stb_o = 1. adr/we/sel/dat_o are driven from the latched values.
  - On the edge where wbm_ack_i = 1:
    - capture wbm_dat_i for reads, or 0 for writes;
    - drop cyc/stb;
    - go to RESP with rsp_valid = 1 and rsp_last = (beats_left == 0).
- **RESP**
  - Hold rsp_* stable until rsp_ready.
  - On handshake:
    - if last, go to IDLE;
    - otherwise addr += SEL_W (modulo 2^ADDR_W, wraps silently), beats_left -= 1, go to REQ.
- wbm_ack_i outside REQ is ignored.
- Writes produce a response per beat.
- cmd_valid while busy is ignored, since cmd_ready = 0.
- Reset mid-operation: on the reset edge, cyc/stb, rsp_valid and busy all go to 0. The command is abandoned with no response.

## Timing
- Command accepted at edge E → cyc/stb high in cycle E+1.
- Ack sampled high at edge A → cyc/stb low and rsp_valid high from A+1.
- Response taken at edge R → next beat's cyc/stb high from R+1. The bus is idle for at least one cycle between beats.
- Zero-wait responder (ack in first stb cycle) with rsp_ready held high: 2 cycles per beat.
- cmd_ready goes high in the cycle after the last response handshake.

## Configuration
- WB_INITIATOR_TIMEOUT_EN defined:
  - A counter runs in REQ, cleared on entry.
  - If it reaches TIMEOUT with no ack, the next edge drops cyc/stb and moves to RESP with rsp_err = 1, rsp_rdata = 0, rsp_last = 1.
  - Remaining beats are discarded.
  - An ack on the same edge the limit is reached wins, and no error is reported.
- Undefined:
  - No counter; REQ waits indefinitely.
  - rsp_err is tied 0.

## Test plan
- Single write: addr 0x3000_0000, wdata 0x0000_1234, sel 0xF, len 0, ack 1 cycle after stb → one bus cycle with we=1 and matching adr/dat/sel; one response with rdata=0, last=1, err=0.
- Read burst: addr 0x3000_0010, len 2, responder returns 0xA, 0xB, 0xC → adr 0x10, 0x14, 0x18 in order; three responses with rdata A, B, C; last only on the third.
- Backpressure: hold rsp_ready=0 for 5 cycles on beat 0 of a 2-beat read → rsp stays stable, no stb during the stall, beat 1 stb starts the cycle after the handshake.
- Wrap: addr 0xFFFF_FFFC, len 1 → second beat address 0x0000_0000.
- Timeout (macro on, TIMEOUT=4, no ack, len 3):
  - cyc/stb high exactly 4 cycles;
  - exactly one response, with err=1, last=1, rdata=0;
  - cmd_ready returns after the handshake.
- Reset mid-burst: reset_n low during beat 1 of REQ → after that edge cyc/stb/rsp_valid/busy are 0 and cmd_ready is 0. After release, cmd_ready = 1 and a new command works normally.

Source files
------------

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic initiator that turns a command/response
// handshake into single-beat or incrementing-burst bus cycles, one beat at
// a time, with per-beat response backpressure.
// Optional watchdog: define WB_INITIATOR_TIMEOUT_EN to abort a beat that is
// not acknowledged within TIMEOUT cycles (remaining beats are discarded).
module wb_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic              busy,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   beats_left;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] timer;
`else
    // Without the watchdog a beat can never be aborted.
    assign rsp_err = 1'b0;
`endif

    // Command/bus/response sequencer; the bus address register doubles as the beat address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            beats_left <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_last   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_dat_o  <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            rsp_err    <= 1'b0;
            timer      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        wbm_we_o   <= cmd_we;
                        wbm_adr_o  <= cmd_addr;
                        wbm_dat_o  <= cmd_wdata;
                        wbm_sel_o  <= cmd_sel;
                        beats_left <= cmd_len;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        timer      <= '0;
`endif
                        state      <= REQ;
                    end else begin
                        cmd_ready  <= 1'b1;
                    end
                end
                REQ: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_last  <= (beats_left == '0);
`ifdef WB_INITIATOR_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef WB_INITIATOR_TIMEOUT_EN
                    else if (timer == TO_W'(TIMEOUT - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_last  <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer     <= timer + TO_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wbm_adr_o  <= wbm_adr_o + ADDR_W'(SEL_W);
                            beats_left <= beats_left - LEN_W'(1);
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
                            timer      <= '0;
`endif
                            state      <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: table-driven bench with a responder model, a response
// scoreboard and hand-written sequences for stall, wrap, reset and watchdog.
module tb_wb_initiator;

    localparam int TB_TIMEOUT = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        last;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [7:0]  len;
        int          ackDelay;
        int          rspStall;
        logic [31:0] rdBase;
        logic [31:0] expLastAdr;
        int          expBeats;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    int checks = 0;
    int failures = 0;

    bus_t        busQ[$];
    rsp_t        rspQ[$];
    logic [31:0] rdQ[$];

    int          ackDelay = 0;
    bit          noAck = 1'b0;
    bit          forceAck = 1'b0;
    int          stbCnt = 0;
    int          stbTotal = 0;
    logic [31:0] lastAckAdr = '0;
    int          stallLeft = 0;
    bit          stallSnapValid = 1'b0;
    rsp_t        stallSnap;
    int          respCount = 0;

    vec_t vecs[6];

    wb_initiator #(
        .ADDR_W (32),
        .DATA_W (32),
        .LEN_W  (8),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_sel  (cmd_sel),
        .cmd_len  (cmd_len),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_last (rsp_last),
        .busy     (busy),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: actual=event required=no-event", name);
    endtask

    // Responder model: acks after ackDelay wait states, checks each acked beat.
    initial begin
        bus_t exp;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o) begin
                stbCnt++;
                stbTotal++;
                if (!noAck && stbCnt > ackDelay) begin
                    wbm_ack_i  = 1'b1;
                    lastAckAdr = wbm_adr_o;
                    if (busQ.size() == 0) begin
                        failNow("bus_unexpected");
                    end else begin
                        exp = busQ.pop_front();
                        checkOutput("bus_beat", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o}, exp);
                    end
                    if (!wbm_we_o && rdQ.size() > 0) wbm_dat_i = rdQ.pop_front();
                    else wbm_dat_i = $urandom;
                end else begin
                    wbm_ack_i = forceAck;
                    wbm_dat_i = $urandom;
                end
            end else begin
                stbCnt    = 0;
                wbm_ack_i = forceAck;
            end
        end
    end

    // Response consumer: optional stall on the first response, then scoreboard compare.
    initial begin
        rsp_t exp;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (stallLeft > 0) begin
                    if (!stallSnapValid) begin
                        stallSnap      = {rsp_rdata, rsp_last, rsp_err};
                        stallSnapValid = 1'b1;
                    end else begin
                        checkOutput("rsp_stable", {rsp_rdata, rsp_last, rsp_err}, stallSnap);
                    end
                    checkOutput("stall_no_stb", wbm_stb_o, 1'b0);
                    stallLeft--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready      = 1'b1;
                    stallSnapValid = 1'b0;
                    if (rspQ.size() == 0) begin
                        failNow("rsp_unexpected");
                    end else begin
                        exp = rspQ.pop_front();
                        checkOutput("rsp_beat", {rsp_rdata, rsp_last, rsp_err}, exp);
                    end
                    respCount++;
                end
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    task automatic driveCmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) failNow("cmd_ready_wait");
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("accept", {cmd_ready, busy, wbm_cyc_o, wbm_stb_o}, 4'b0111);
    endtask

    task automatic waitIdle(input int bound, output int cycles);
        cycles = 0;
        while (!cmd_ready && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        if (!cmd_ready) failNow("idle_wait");
    endtask

    task automatic applyStimulus(input vec_t v);
        int   base;
        int   waited;
        bus_t b;
        rsp_t r;
        base           = respCount;
        ackDelay       = v.ackDelay;
        stallLeft      = v.rspStall;
        stallSnapValid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            b.we  = v.we;
            b.adr = v.addr + 32'(4 * i);
            b.dat = v.wdata;
            b.sel = v.sel;
            busQ.push_back(b);
            if (!v.we) rdQ.push_back(v.rdBase + 32'(i));
            r.rdata = v.we ? 32'h0 : v.rdBase + 32'(i);
            r.last  = (i == int'(v.len));
            r.err   = 1'b0;
            rspQ.push_back(r);
        end
        driveCmd(v.we, v.addr, v.wdata, v.sel, v.len);
        waitIdle(500, waited);
        checkOutput("cycles", waited, (int'(v.len) + 1) * (2 + v.ackDelay) + v.rspStall);
        checkOutput("beats", respCount - base, v.expBeats);
        checkOutput("last_adr", lastAckAdr, v.expLastAdr);
        checkOutput("queues_empty", {rspQ.size(), busQ.size()}, 64'd0);
    endtask

    // Main sequence.
    initial begin
        int base;
        int waited;
        int n;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_sel   = '0;
        cmd_len   = '0;
        rsp_ready = 1'b1;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;

        vecs[0] = '{we:1'b1, addr:32'h3000_0000, wdata:32'h0000_1234, sel:4'hF, len:8'd0,
                    ackDelay:1, rspStall:0, rdBase:32'h0, expLastAdr:32'h3000_0000, expBeats:1};
        vecs[1] = '{we:1'b0, addr:32'h3000_0010, wdata:32'h0, sel:4'hF, len:8'd2,
                    ackDelay:1, rspStall:0, rdBase:32'hA, expLastAdr:32'h3000_0018, expBeats:3};
        vecs[2] = '{we:1'b0, addr:32'h3000_0020, wdata:32'h0, sel:4'hF, len:8'd1,
                    ackDelay:0, rspStall:5, rdBase:32'h100, expLastAdr:32'h3000_0024, expBeats:2};
        vecs[3] = '{we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, sel:4'hF, len:8'd1,
                    ackDelay:0, rspStall:0, rdBase:32'h55, expLastAdr:32'h0000_0000, expBeats:2};
        vecs[4] = '{we:1'b1, addr:32'h3000_0100, wdata:32'hDEAD_BEEF, sel:4'h3, len:8'd3,
                    ackDelay:0, rspStall:0, rdBase:32'h0, expLastAdr:32'h3000_010C, expBeats:4};
        vecs[5] = '{we:1'b1, addr:32'hFFFF_FFF8, wdata:32'h0000_CAFE, sel:4'hC, len:8'd2,
                    ackDelay:2, rspStall:2, rdBase:32'h0, expLastAdr:32'h0000_0000, expBeats:3};

        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {cmd_ready, rsp_valid, rsp_err, rsp_last, busy,
                                   wbm_cyc_o, wbm_stb_o, wbm_we_o}, 8'h00);
        checkOutput("reset_data", {wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_rdata}, 100'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // Acks while idle must not create responses or start a cycle.
        forceAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_ack_ignored", {cmd_ready, rsp_valid, busy, wbm_cyc_o}, 4'b1000);
        end
        forceAck = 1'b0;
        @(negedge clk);

`ifdef WB_INITIATOR_TIMEOUT_EN
        // Unacknowledged burst is aborted after TB_TIMEOUT stb cycles with one error response.
        noAck    = 1'b1;
        stbTotal = 0;
        base     = respCount;
        rspQ.push_back('{rdata:32'h0, last:1'b1, err:1'b1});
        driveCmd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 8'd3);
        waitIdle(200, waited);
        checkOutput("timeout_stb_cycles", stbTotal, TB_TIMEOUT);
        checkOutput("timeout_responses", respCount - base, 1);
        checkOutput("timeout_ready", cmd_ready, 1'b1);
        noAck = 1'b0;
`endif

        // Reset during beat 1 of a 3-beat read abandons the command.
        ackDelay = 3;
        base     = respCount;
        for (int i = 0; i < 3; i++) begin
            busQ.push_back('{we:1'b0, adr:32'h3000_0300 + 32'(4 * i), dat:32'h0, sel:4'hF});
            rdQ.push_back(32'h700 + 32'(i));
            rspQ.push_back('{rdata:32'h700 + 32'(i), last:(i == 2), err:1'b0});
        end
        driveCmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 8'd2);
        n = 0;
        while (!(respCount == base + 1 && wbm_stb_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(respCount == base + 1 && wbm_stb_o)) failNow("beat1_wait");
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset", {wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready}, 5'b0);
        busQ.delete();
        rdQ.delete();
        rspQ.delete();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_mid_reset", cmd_ready, 1'b1);
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
